// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and a per-frame runtime format
// (divisor, 5-8 data bits, none/even/odd parity, 1 or 2 stop bits).
module uart_tx_cfg #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tx_dv,
  input  logic [7:0]                    i_tx_byte,
  input  logic [CNT_WIDTH-1:0]          i_cfg_clks_per_bit,
  input  logic [1:0]                    i_cfg_data_bits,
  input  logic [1:0]                    i_cfg_parity,
  input  logic                          i_cfg_stop2,
  output logic                          o_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic                          o_tx_active,
  output logic                          o_tx_serial,
  output logic                          o_tx_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 ready_q, overflow_q;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q, cpb_q;
  logic [7:0]           shift_q;
  logic [2:0]           nbits_m1_q, bit_idx_q;
  logic                 par_en_q, par_bit_q, stop2_q, stop_idx_q;
  logic                 serial_q, active_q, done_q;

  logic                 push, pop, cnt_end, stop_end;
  logic [7:0]           head_masked;
  logic [CNT_WIDTH-1:0] cfg_cpb;

  always_comb begin
    push        = i_tx_dv & ready_q;
    cnt_end     = (cnt_q == cpb_q - CNT_WIDTH'(1));
    stop_end    = (state_q == StStop) && cnt_end && (!stop2_q || stop_idx_q);
    pop         = (level_q != '0) && ((state_q == StIdle) || stop_end);
    level_d     = level_q + LW'(push) - LW'(pop);
    head_masked = mem_q[rd_ptr_q] & (8'hFF >> (2'd3 - i_cfg_data_bits));
    cfg_cpb     = (i_cfg_clks_per_bit < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : i_cfg_clks_per_bit;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_tx_byte;
  end

  // Full is judged on the registered ready, so a pop in the same cycle cannot admit a write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      ready_q    <= (level_d != LW'(FIFO_DEPTH));
      overflow_q <= i_tx_dv & ~ready_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cpb_q      <= CNT_WIDTH'(2);
      shift_q    <= '0;
      nbits_m1_q <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= stop_end;
      if (pop) begin
        // Format is captured here and held for the whole frame.
        state_q    <= StStart;
        cnt_q      <= '0;
        cpb_q      <= cfg_cpb;
        shift_q    <= head_masked;
        nbits_m1_q <= 3'd4 + {1'b0, i_cfg_data_bits};
        par_en_q   <= (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
        par_bit_q  <= (^head_masked) ^ (i_cfg_parity == 2'b10);
        stop2_q    <= i_cfg_stop2;
        serial_q   <= 1'b0;
        active_q   <= 1'b1;
      end else if (state_q == StIdle) begin
        serial_q <= 1'b1;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_end ? '0 : cnt_q + CNT_WIDTH'(1);
        if (cnt_end) begin
          case (state_q)
            StStart: begin
              state_q   <= StData;
              serial_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= '0;
            end
            StData: begin
              if (bit_idx_q == nbits_m1_q) begin
                state_q    <= par_en_q ? StParity : StStop;
                serial_q   <= par_en_q ? par_bit_q : 1'b1;
                stop_idx_q <= 1'b0;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                serial_q  <= shift_q[0];
                shift_q   <= shift_q >> 1;
              end
            end
            StParity: begin
              state_q    <= StStop;
              serial_q   <= 1'b1;
              stop_idx_q <= 1'b0;
            end
            StStop: begin
              // Two stop bits are two back-to-back CPB periods.
              if (stop2_q && !stop_idx_q) begin
                stop_idx_q <= 1'b1;
              end else begin
                state_q  <= StIdle;
                serial_q <= 1'b1;
                active_q <= 1'b0;
              end
            end
            default: begin
              state_q  <= StIdle;
              serial_q <= 1'b1;
              active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_tx_ready   = ready_q;
  assign o_fifo_level = level_q;
  assign o_overflow   = overflow_q;
  assign o_tx_active  = active_q;
  assign o_tx_serial  = serial_q;
  assign o_tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected frames are queued on write and checked
// cycle by cycle on the serial line by a monitor.
module tb_uart_tx_cfg;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;

  typedef struct {
    logic [7:0] data;
    int         n;
    logic [1:0] par;
    bit         stop2;
    int         cpb;
  } frame_t;

  logic                   clk;
  logic                   rst_n;
  logic                   tx_dv;
  logic [7:0]             tx_byte;
  logic [CntW-1:0]        cfg_cpb;
  logic [1:0]             cfg_data_bits;
  logic [1:0]             cfg_parity;
  logic                   cfg_stop2;
  logic                   o_tx_ready;
  logic [$clog2(Depth):0] o_fifo_level;
  logic                   o_overflow;
  logic                   o_tx_active;
  logic                   o_tx_serial;
  logic                   o_tx_done;

  int     n_asserts = 0;
  int     n_fail    = 0;
  frame_t sb[$];

  uart_tx_cfg #(.FIFO_DEPTH(Depth), .CNT_WIDTH(CntW)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_tx_dv            (tx_dv),
    .i_tx_byte          (tx_byte),
    .i_cfg_clks_per_bit (cfg_cpb),
    .i_cfg_data_bits    (cfg_data_bits),
    .i_cfg_parity       (cfg_parity),
    .i_cfg_stop2        (cfg_stop2),
    .o_tx_ready         (o_tx_ready),
    .o_fifo_level       (o_fifo_level),
    .o_overflow         (o_overflow),
    .o_tx_active        (o_tx_active),
    .o_tx_serial        (o_tx_serial),
    .o_tx_done          (o_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick();
    tx_dv   = 1'b0;
  endtask

  // Format the frame will be sent with, assuming config is stable until its pop.
  function automatic void push_exp(input logic [7:0] b);
    frame_t f;
    f.data  = b;
    f.n     = 5 + int'(cfg_data_bits);
    f.par   = cfg_parity;
    f.stop2 = cfg_stop2;
    f.cpb   = (cfg_cpb < 2) ? 2 : int'(cfg_cpb);
    sb.push_back(f);
  endfunction

  function automatic int frame_bits(input frame_t f, output logic [11:0] bits);
    logic p;
    int   k;
    p       = 1'b0;
    bits    = '1;
    bits[0] = 1'b0;
    k       = 1;
    for (int i = 0; i < f.n; i++) begin
      bits[k] = f.data[i];
      p       = p ^ f.data[i];
      k++;
    end
    if (f.par == 2'b01 || f.par == 2'b10) begin
      bits[k] = (f.par == 2'b10) ? ~p : p;
      k++;
    end
    return k + (f.stop2 ? 2 : 1);
  endfunction

  task automatic run_frame();
    frame_t     f;
    logic [11:0] bits;
    int         nb;
    bit         more;
    more = 1'b1;
    while (more) begin
      more = 1'b0;
      chk_val("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      f  = sb.pop_front();
      nb = frame_bits(f, bits);
      for (int b = 0; b < nb; b++) begin
        for (int c = 0; c < f.cpb; c++) begin
          if (b != 0 || c != 0) begin
            @(negedge clk);
            if (rst_n !== 1'b1) return;
            chk_bit("done_in_frame", o_tx_done, 1'b0);
          end
          chk_bit($sformatf("byte%02h_bit%0d", f.data, b), o_tx_serial, bits[b]);
          chk_bit("active_in_frame", o_tx_active, 1'b1);
        end
      end
      @(negedge clk);
      if (rst_n !== 1'b1) return;
      chk_bit("done_pulse", o_tx_done, 1'b1);
      if (sb.size() != 0) chk_bit("zero_gap", o_tx_serial, 1'b0);
      more = (o_tx_serial === 1'b0);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_tx_serial === 1'b0) run_frame();
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && !(sb.size() == 0 && o_tx_active === 1'b0 && o_fifo_level == 0)) begin
      tick();
      i++;
    end
    chk_val("idle_within_budget", 32'(i < budget), 32'd1);
    tick();
    tick();
  endtask

  initial begin : stimulus
    rst_n         = 1'b0;
    tx_dv         = 1'b0;
    tx_byte       = '0;
    cfg_cpb       = 16'd4;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    repeat (3) tick();
    chk_val("rst_level", 32'(o_fifo_level), 32'd0);
    chk_bit("rst_ready", o_tx_ready, 1'b1);
    chk_bit("rst_serial", o_tx_serial, 1'b1);
    chk_bit("rst_active", o_tx_active, 1'b0);
    chk_bit("rst_done", o_tx_done, 1'b0);
    chk_bit("rst_overflow", o_overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // 8N1, CPB=4, 0xA5, with one-cycle start latency
    push_exp(8'hA5);
    write_byte(8'hA5);
    chk_bit("t1_not_started", o_tx_serial, 1'b1);
    chk_val("t1_level_1", 32'(o_fifo_level), 32'd1);
    tick();
    chk_bit("t1_start_low", o_tx_serial, 1'b0);
    chk_bit("t1_active", o_tx_active, 1'b1);
    chk_val("t1_level_0", 32'(o_fifo_level), 32'd0);
    wait_idle(200);

    // 7E1, CPB=4, 0x35
    cfg_data_bits = 2'd2;
    cfg_parity    = 2'b01;
    push_exp(8'h35);
    write_byte(8'h35);
    wait_idle(200);

    // 5O2, CPB=3, 0xFF
    cfg_cpb       = 16'd3;
    cfg_data_bits = 2'd0;
    cfg_parity    = 2'b10;
    cfg_stop2     = 1'b1;
    push_exp(8'hFF);
    write_byte(8'hFF);
    wait_idle(200);

    // Fill FIFO, overflow, back-to-back frames (6 bits, reserved parity = none)
    cfg_cpb       = 16'd2;
    cfg_data_bits = 2'd1;
    cfg_parity    = 2'b11;
    cfg_stop2     = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_exp(8'(i));
      write_byte(8'(i));
      if (i == 2) chk_val("t4_write_pop_level", 32'(o_fifo_level), 32'd1);
    end
    chk_val("t4_level_full", 32'(o_fifo_level), 32'd4);
    chk_bit("t4_not_ready", o_tx_ready, 1'b0);
    write_byte(8'h06);
    chk_bit("t4_overflow", o_overflow, 1'b1);
    chk_val("t4_level_kept", 32'(o_fifo_level), 32'd4);
    tick();
    chk_bit("t4_overflow_pulse", o_overflow, 1'b0);
    wait_idle(400);
    repeat (10) begin
      tick();
      chk_bit("t4_no_extra_frame", o_tx_serial, 1'b1);
    end

    // Reset during data bit 3
    cfg_cpb       = 16'd4;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'b00;
    push_exp(8'h5A);
    write_byte(8'h5A);
    repeat (18) tick();
    rst_n = 1'b0;
    tick();
    chk_bit("t5_serial", o_tx_serial, 1'b1);
    chk_bit("t5_active", o_tx_active, 1'b0);
    chk_val("t5_level", 32'(o_fifo_level), 32'd0);
    chk_bit("t5_done", o_tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk_bit("t5_no_done", o_tx_done, 1'b0);
    end
    push_exp(8'h3C);
    write_byte(8'h3C);
    wait_idle(200);

    // CPB=1 clamps to 2; mid-frame config change applies only to the next frame
    cfg_cpb       = 16'd1;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'b00;
    push_exp(8'hC3);
    write_byte(8'hC3);
    repeat (3) tick();
    cfg_data_bits = 2'd0;
    cfg_parity    = 2'b01;
    cfg_cpb       = 16'd3;
    push_exp(8'h16);
    write_byte(8'h16);
    wait_idle(300);
    cfg_cpb = 16'd0;
    push_exp(8'h81);
    write_byte(8'h81);
    wait_idle(200);

    chk_bit("end_serial_idle", o_tx_serial, 1'b1);
    chk_bit("end_inactive", o_tx_active, 1'b0);
    chk_val("end_scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
